// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit output stage.
package i2s_pkg;

  localparam int unsigned SAMPLE_W          = 24;
  localparam int unsigned DEFAULT_SLOT_BITS = 32;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous stereo-pair FIFO with registered level; pushes when full are dropped.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  stereo_sample_t         wr_data,
  output stereo_sample_t         rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  stereo_sample_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Buffers stereo pairs and serializes them as I2S (bck/lrck/sdata) from clk.
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BCK_DIV    = 2,
  parameter int unsigned SLOT_BITS  = DEFAULT_SLOT_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        mute,
  input  logic                        l_data_valid,
  input  logic                        r_data_valid,
  input  logic [SAMPLE_W-1:0]         l_data_in,
  input  logic [SAMPLE_W-1:0]         r_data_in,
  output logic                        i2s_bck,
  output logic                        i2s_lrck,
  output logic                        i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_count
`endif
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [SAMPLE_W-1:0]   l_hold;
  logic                  tc;
  logic                  shift_evt;
  logic                  frame_load;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  stereo_sample_t        push_pair;
  stereo_sample_t        head_pair;
  stereo_sample_t        load_pair;

  always_comb begin
    tc          = (div_cnt == DIV_W'(BCK_DIV - 1));
    shift_evt   = run && tc && i2s_bck;
    bit_cnt_nxt = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
    frame_load  = shift_evt && (bit_cnt_nxt == '0);
    fifo_flush  = !run;
    // Full-FIFO pushes are dropped inside the FIFO; fullness is pre-pop.
    fifo_push   = run && r_data_valid;
    fifo_pop    = frame_load && !fifo_empty;
    push_pair.l = l_data_valid ? l_data_in : l_hold;
    push_pair.r = r_data_in;
    load_pair   = (mute || fifo_empty) ? '0 : head_pair;
    frame_word  = (FRAME_BITS'(load_pair.l) << (FRAME_BITS - SAMPLE_W))
                | (FRAME_BITS'(load_pair.r) << (SLOT_BITS - SAMPLE_W));
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (push_pair),
    .rd_data (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Bit counter presets to the last slot bit so the first shift event loads a frame.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt   <= '0;
      i2s_bck   <= 1'b0;
      bit_cnt   <= CNT_W'(FRAME_BITS - 1);
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      shreg     <= '0;
      l_hold    <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
      if (tc) i2s_bck <= ~i2s_bck;
      if (shift_evt) begin
        bit_cnt   <= bit_cnt_nxt;
        i2s_lrck  <= (bit_cnt_nxt >= CNT_W'(SLOT_BITS));
        i2s_sdata <= shreg[FRAME_BITS-1];
        shreg     <= frame_load ? frame_word : {shreg[FRAME_BITS-2:0], 1'b0};
      end
      if (l_data_valid) l_hold <= l_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= fifo_push && fifo_full;
      underrun <= frame_load && fifo_empty;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) underrun_count <= '0;
    else if (underrun && (underrun_count != '1)) underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer against a queue-based frame model.
module tb_i2s_tx_serializer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BCK_DIV    = 2;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned FRAME_CYC  = FRAME_BITS * 2 * BCK_DIV;
  localparam int unsigned FIRST_EVT  = 2 * BCK_DIV;

  logic        clk = 1'b0;
  logic        reset, run, mute, l_data_valid, r_data_valid;
  logic [23:0] l_data_in, r_data_in;
  logic        i2s_bck, i2s_lrck, i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [47:0] mq[$];
  logic [47:0] exp_frames[$];
  logic [1:0]  bitq[$];
  logic [23:0] hold_m;
  int unsigned edge_n;
  logic [15:0] cnt_m;
  logic        ur_prev;
  logic        bck_q = 1'b0;
  int          ov_seen;

  i2s_tx_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BCK_DIV    (BCK_DIV),
    .SLOT_BITS  (SLOT_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .mute           (mute),
    .l_data_valid   (l_data_valid),
    .r_data_valid   (r_data_valid),
    .l_data_in      (l_data_in),
    .r_data_in      (r_data_in),
    .i2s_bck        (i2s_bck),
    .i2s_lrck       (i2s_lrck),
    .i2s_sdata      (i2s_sdata),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underrun       (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // DAC view: capture {lrck, sdata} on every rising bit clock.
  always @(negedge clk) begin
    if (i2s_bck && !bck_q) bitq.push_back({i2s_lrck, i2s_sdata});
    bck_q = i2s_bck;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs now applied, then compare pulses and level.
  task automatic tick();
    logic        ov_e, ur_e;
    logic [23:0] l_pair;
    logic [47:0] p;
    int          lvl;
    ov_e = 1'b0;
    ur_e = 1'b0;
    if (reset || !run) begin
      mq.delete();
      hold_m = '0;
      edge_n = 0;
    end else begin
      edge_n++;
      lvl    = mq.size();
      l_pair = l_data_valid ? l_data_in : hold_m;
      if (edge_n >= FIRST_EVT && ((edge_n - FIRST_EVT) % FRAME_CYC) == 0) begin
        if (lvl == 0) begin
          ur_e = 1'b1;
          exp_frames.push_back('0);
        end else begin
          p = mq.pop_front();
          exp_frames.push_back(mute ? 48'h0 : p);
        end
      end
      if (r_data_valid) begin
        if (lvl == FIFO_DEPTH) ov_e = 1'b1;
        else mq.push_back({l_pair, r_data_in});
      end
      if (l_data_valid) hold_m = l_data_in;
    end
    if (reset) cnt_m = '0;
    else if (ur_prev && cnt_m != 16'hFFFF) cnt_m++;
    ur_prev = ur_e;
    @(posedge clk);
    #1;
    chk("overflow", overflow, ov_e);
    chk("underrun", underrun, ur_e);
    chk("fifo_level", fifo_level, mq.size());
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_count", underrun_count, cnt_m);
`endif
  endtask

  // Frame k, bit b was sampled at capture index 1+64k+b (index 0 precedes the first shift).
  task automatic check_frames(input string tag, input int n);
    logic [23:0] l, r;
    logic [1:0]  s;
    logic        pad, lr_ok;
    logic        enough;
    enough = (bitq.size() >= FRAME_BITS * n + 1) && (exp_frames.size() >= n);
    chk({tag, "_frames_captured"}, enough, 1'b1);
    if (enough) begin
      for (int k = 0; k < n; k++) begin
        l = '0; r = '0; pad = 1'b0; lr_ok = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++) begin
          s = bitq[1 + FRAME_BITS * k + b];
          if (s[1] !== (b >= SLOT_BITS)) lr_ok = 1'b0;
          if (b >= 1 && b <= 24) l = {l[22:0], s[0]};
          else if (b >= SLOT_BITS + 1 && b <= SLOT_BITS + 24) r = {r[22:0], s[0]};
          else pad = pad | s[0];
        end
        chk($sformatf("%s_f%0d_left", tag, k), l, exp_frames[k][47:24]);
        chk($sformatf("%s_f%0d_right", tag, k), r, exp_frames[k][23:0]);
        chk($sformatf("%s_f%0d_pad", tag, k), pad, 1'b0);
        chk($sformatf("%s_f%0d_lrck", tag, k), lr_ok, 1'b1);
      end
    end
  endtask

  task automatic start_run();
    bitq.delete();
    exp_frames.delete();
    run = 1'b1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mute = 1'b0;
    l_data_valid = 1'b0; r_data_valid = 1'b0;
    l_data_in = '0; r_data_in = '0;
    hold_m = '0; edge_n = 0; cnt_m = '0; ur_prev = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset_bck", i2s_bck, 1'b0);
    chk("reset_lrck", i2s_lrck, 1'b0);
    chk("reset_sdata", i2s_sdata, 1'b0);
    reset = 1'b0;
    tick();

    // Single pair pushed with both strobes, in the first run cycle
    start_run();
    l_data_valid = 1'b1; r_data_valid = 1'b1;
    l_data_in = 24'h800001; r_data_in = 24'h7FFFFE;
    tick();
    l_data_valid = 1'b0; r_data_valid = 1'b0;
    repeat (2 * FRAME_CYC + 2) tick();
    check_frames("single", 2);
    chk("single_first_sdata_bit", bitq[2][0], 1'b1);
    run = 1'b0;
    tick();

    // Underrun: empty FIFO for three frames
    reset = 1'b1; tick(); reset = 1'b0;
    start_run();
    repeat (3 * FRAME_CYC + 3) tick();
    check_frames("underrun", 3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_count_3", underrun_count, 16'd3);
`endif
    run = 1'b0;
    tick();

    // Overflow: pushes ignored while idle, then five back-to-back pushes into depth 4
    for (int i = 1; i <= 5; i++) begin
      l_data_valid = 1'b1; r_data_valid = 1'b1;
      l_data_in = 24'(i); r_data_in = 24'(i);
      tick();
    end
    l_data_valid = 1'b0; r_data_valid = 1'b0;
    chk("idle_push_level", fifo_level, 3'd0);
    start_run();
    repeat (FIRST_EVT) tick();
    ov_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      l_data_valid = 1'b1; r_data_valid = 1'b1;
      l_data_in = 24'(i); r_data_in = 24'(i);
      tick();
      ov_seen += int'(overflow);
    end
    l_data_valid = 1'b0; r_data_valid = 1'b0;
    chk("overflow_pulses", ov_seen, 1);
    chk("overflow_level", fifo_level, 3'd4);
    repeat (5 * FRAME_CYC + 3 - FIRST_EVT - 5) tick();
    check_frames("overflow", 5);
    run = 1'b0;
    tick();

    // Split strobes: left, then right three cycles later
    start_run();
    repeat (FIRST_EVT) tick();
    l_data_valid = 1'b1; l_data_in = 24'h123456;
    tick();
    l_data_valid = 1'b0; l_data_in = 24'($urandom);
    repeat (2) tick();
    r_data_valid = 1'b1; r_data_in = 24'h654321;
    tick();
    r_data_valid = 1'b0;
    repeat (2 * FRAME_CYC + 3 - FIRST_EVT - 4) tick();
    check_frames("split", 2);
    run = 1'b0;
    tick();

    // Randomized strobes, data and mute
    start_run();
    for (int c = 0; c < 6 * FRAME_CYC + 3; c++) begin
      l_data_valid = ($urandom % 24) == 0;
      r_data_valid = ($urandom % 40) == 0;
      l_data_in = 24'($urandom);
      r_data_in = 24'($urandom);
      if (c % 300 == 0) mute = 1'($urandom % 2);
      tick();
    end
    l_data_valid = 1'b0; r_data_valid = 1'b0; mute = 1'b0;
    check_frames("random", 6);
    run = 1'b0;
    tick();

    // Mute with pairs queued, then reset mid-frame
    start_run();
    repeat (FIRST_EVT) tick();
    for (int i = 0; i < 3; i++) begin
      l_data_valid = 1'b1; r_data_valid = 1'b1;
      l_data_in = 24'($urandom); r_data_in = 24'($urandom);
      tick();
    end
    l_data_valid = 1'b0; r_data_valid = 1'b0;
    mute = 1'b1;
    repeat (3 * FRAME_CYC + 3 - FIRST_EVT - 3) tick();
    check_frames("mute", 3);
    chk("mute_level", fifo_level, 3'd1);
    repeat (100) tick();
    reset = 1'b1;
    tick();
    chk("midreset_bck", i2s_bck, 1'b0);
    chk("midreset_lrck", i2s_lrck, 1'b0);
    chk("midreset_sdata", i2s_sdata, 1'b0);
    chk("midreset_level", fifo_level, 3'd0);
    reset = 1'b0; run = 1'b0; mute = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
